sdfm_shift_arbiter: RTL and testbench

SDFM_SHIFT_ARBITER -- requirements
Module: sdfm_shift_arbiter

---
 rtl/sdfm_shift_arbiter_pkg.sv | 19 +
 rtl/sdfm_shift_arbiter_if.sv | 30 +++
 rtl/sdfm_shift_arbiter_shift.sv | 15 +
 rtl/sdfm_shift_arbiter.sv | 132 +++++++++++++
 tb/tb_sdfm_shift_arbiter.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/sdfm_shift_arbiter_pkg.sv
// Shared constants and helpers for the SDFM shift arbiter.
package sdfm_shift_arbiter_pkg;

  localparam int DATA_W      = 32;  // filter result width
  localparam int BITS_W      = 5;   // shift-amount field width
  localparam int MAX_SHIFT   = 24;  // largest shift actually applied
  localparam int NCH_DEFAULT = 4;   // default number of channels
  localparam int CH_W        = 3;   // width of a channel index (up to 8 channels)

  // Limit a requested shift to the largest supported amount.
  function automatic logic [BITS_W-1:0] clamp_shift(input logic [BITS_W-1:0] bits);
    if (bits > BITS_W'(MAX_SHIFT)) begin
      return BITS_W'(MAX_SHIFT);
    end else begin
      return bits;
    end
  endfunction

endpackage

// File: rtl/sdfm_shift_arbiter_if.sv
// Channel capture and result bus of the SDFM shift arbiter.
interface sdfm_shift_arbiter_if
  import sdfm_shift_arbiter_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT
) ();

  logic [NCH-1:0]        ch_valid;
  logic [NCH*DATA_W-1:0] ch_data;
  logic [NCH*BITS_W-1:0] ch_bits;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic [CH_W-1:0]       out_ch;
  logic [NCH-1:0]        ovf;
  logic [NCH-1:0]        ovf_clr;

  // Producer of filter results and consumer of shifted output.
  modport master (
    output ch_valid, ch_data, ch_bits, out_ready, ovf_clr,
    input  out_valid, out_data, out_ch, ovf
  );

  // The arbiter itself.
  modport slave (
    input  ch_valid, ch_data, ch_bits, out_ready, ovf_clr,
    output out_valid, out_data, out_ch, ovf
  );

endinterface

// File: rtl/sdfm_shift_arbiter_shift.sv
// Arithmetic right shifter with sign extension; shift capped at MAX_SHIFT.
module sdfm_shift_arbiter_shift
  import sdfm_shift_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [BITS_W-1:0] bits_i,
  output logic [DATA_W-1:0] data_o
);

  // Signed shift so the sign bit replicates into the vacated positions.
  always_comb begin
    data_o = $signed(data_i) >>> clamp_shift(bits_i);
  end

endmodule

// File: rtl/sdfm_shift_arbiter.sv
// Round-robin arbiter sharing one output shifter among NCH filter channels.
module sdfm_shift_arbiter
  import sdfm_shift_arbiter_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  sdfm_shift_arbiter_if.slave   bus
);

  logic [DATA_W-1:0] slot_data_q [NCH];
  logic [DATA_W-1:0] slot_data_d [NCH];
  logic [BITS_W-1:0] slot_bits_q [NCH];
  logic [BITS_W-1:0] slot_bits_d [NCH];
  logic [NCH-1:0]    pending_q, pending_d;
  logic [NCH-1:0]    ovf_q, ovf_d, ovf_set_s;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;

  logic              accept_s, found_s, do_grant_s;
  logic [CH_W-1:0]   grant_s;
  logic [DATA_W-1:0] mux_data_s, shift_out_s;
  logic [BITS_W-1:0] mux_bits_s;

  // Returns {found, index} of the first pending channel after 'last', wrapping.
  function automatic logic [CH_W:0] rr_pick(input logic [NCH-1:0] pend,
                                            input logic [CH_W-1:0] last);
    logic            found;
    logic [CH_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if (!found && pend[k] && (k == ((int'(last) + i) % NCH))) begin
          found = 1'b1;
          idx   = CH_W'(k);
        end
      end
    end
    return {found, idx};
  endfunction

  // Arbitration decision and granted-slot mux feeding the shifter.
  always_comb begin
    accept_s            = !out_valid_q || bus.out_ready;
    {found_s, grant_s}  = rr_pick(pending_q, last_grant_q);
    do_grant_s          = accept_s && found_s;
    mux_data_s          = '0;
    mux_bits_s          = '0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_s == CH_W'(k)) begin
        mux_data_s = slot_data_q[k];
        mux_bits_s = slot_bits_q[k];
      end
    end
  end

  sdfm_shift_arbiter_shift u_shift (
    .data_i (mux_data_s),
    .bits_i (mux_bits_s),
    .data_o (shift_out_s)
  );

  // Next state of capture slots, pending flags, overrun flags and output stage.
  always_comb begin
    pending_d    = pending_q;
    ovf_set_s    = '0;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    last_grant_d = last_grant_q;
    for (int k = 0; k < NCH; k++) begin
      slot_data_d[k] = slot_data_q[k];
      slot_bits_d[k] = slot_bits_q[k];
      if (bus.ch_valid[k]) begin
        // A fresh capture keeps the slot pending; it is an overrun only when
        // the old value was still waiting and is not leaving this cycle.
        slot_data_d[k] = bus.ch_data[k*DATA_W +: DATA_W];
        slot_bits_d[k] = bus.ch_bits[k*BITS_W +: BITS_W];
        pending_d[k]   = 1'b1;
        ovf_set_s[k]   = pending_q[k] && !(do_grant_s && (grant_s == CH_W'(k)));
      end else if (do_grant_s && (grant_s == CH_W'(k))) begin
        pending_d[k]   = 1'b0;
      end else begin
        pending_d[k]   = pending_q[k];
      end
    end
    ovf_d = (ovf_q & ~bus.ovf_clr) | ovf_set_s;
    if (do_grant_s) begin
      out_valid_d  = 1'b1;
      out_data_d   = shift_out_s;
      out_ch_d     = grant_s;
      last_grant_d = grant_s;
    end else if (accept_s) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // State registers; reset discards any captured or in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_data_q  <= '{default: '0};
      slot_bits_q  <= '{default: '0};
      pending_q    <= '0;
      ovf_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      last_grant_q <= CH_W'(NCH - 1);
    end else begin
      slot_data_q  <= slot_data_d;
      slot_bits_q  <= slot_bits_d;
      pending_q    <= pending_d;
      ovf_q        <= ovf_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sdfm_shift_arbiter.sv
// Directed self-checking bench for sdfm_shift_arbiter (NCH = 4).
module tb_sdfm_shift_arbiter;
  import sdfm_shift_arbiter_pkg::*;

  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sdfm_shift_arbiter_if #(.NCH(NCH)) bus ();

  sdfm_shift_arbiter #(.NCH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int k, input logic [31:0] d, input logic [4:0] b);
    bus.ch_valid[k]          = 1'b1;
    bus.ch_data[k*32 +: 32]  = d;
    bus.ch_bits[k*5 +: 5]    = b;
  endtask

  task automatic idle();
    bus.ch_valid = '0;
    bus.ovf_clr  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Single capture on an idle arbiter; result expected two cycles later.
  task automatic one_shot(input string tag, input int k, input logic [31:0] d,
                          input logic [4:0] b, input logic [31:0] exp);
    strobe(k, d, b);
    tick();
    idle();
    tick();
    chk({tag, "_valid"}, bus.out_valid, 32'd1);
    chk({tag, "_ch"}, bus.out_ch, k);
    chk({tag, "_data"}, bus.out_data, exp);
    tick();
  endtask

  initial begin
    bus.ch_valid  = '0;
    bus.ch_data   = '0;
    bus.ch_bits   = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = '0;
    rst           = 1'b1;
    tick();
    tick();
    chk("rst_valid", bus.out_valid, 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_ch", bus.out_ch, 32'd0);
    chk("rst_ovf", bus.ovf, 32'd0);
    rst = 1'b0;
    tick();

    // Minimum latency and sign extension of a negative value.
    bus.out_ready = 1'b1;
    strobe(0, 32'h8000_0000, 5'd4);
    tick();
    idle();
    chk("lat_c1_valid", bus.out_valid, 32'd0);
    tick();
    chk("lat_c2_valid", bus.out_valid, 32'd1);
    chk("lat_c2_ch", bus.out_ch, 32'd0);
    chk("lat_c2_data", bus.out_data, 32'hF800_0000);
    tick();
    chk("lat_c3_valid", bus.out_valid, 32'd0);

    // Four simultaneous strobes drain in channel order, one per cycle.
    do_reset();
    for (int k = 0; k < NCH; k++) strobe(k, 32'h100, 5'(k));
    tick();
    idle();
    for (int k = 0; k < NCH; k++) begin
      tick();
      chk("rr_valid", bus.out_valid, 32'd1);
      chk("rr_ch", bus.out_ch, k);
      chk("rr_data", bus.out_data, 32'h100 >> k);
    end
    tick();
    chk("rr_empty", bus.out_valid, 32'd0);

    // Shift range boundaries.
    one_shot("sh31", 2, 32'h7FFF_FFFF, 5'd31, 32'h0000_007F);
    one_shot("sh25neg", 1, 32'h8000_0000, 5'd25, 32'hFFFF_FF80);
    one_shot("sh24neg", 0, 32'h8000_0000, 5'd24, 32'hFFFF_FF80);
    one_shot("sh0", 3, 32'hFFFF_0000, 5'd0, 32'hFFFF_0000);
    one_shot("sh23", 2, 32'h1234_5678, 5'd23, 32'h0000_0024);
    one_shot("sh1neg", 3, 32'hFFFF_FFF1, 5'd1, 32'hFFFF_FFF8);

    // Strobe on the granted channel at the grant edge: no overrun, both delivered.
    strobe(0, 32'hA, 5'd0);
    tick();
    strobe(0, 32'hB, 5'd0);
    tick();
    idle();
    chk("regrant_first", bus.out_data, 32'hA);
    chk("regrant_ovf", bus.ovf, 32'd0);
    tick();
    chk("regrant_second", bus.out_data, 32'hB);
    chk("regrant_valid", bus.out_valid, 32'd1);
    tick();
    chk("regrant_empty", bus.out_valid, 32'd0);
    chk("regrant_ovf2", bus.ovf, 32'd0);

    // Stalled output: channel 1 strobes twice and overruns.
    bus.out_ready = 1'b0;
    strobe(0, 32'h11, 5'd0);
    tick();
    idle();
    tick();
    strobe(1, 32'h22, 5'd0);
    tick();
    strobe(1, 32'h33, 5'd0);
    chk("stall_hold_data", bus.out_data, 32'h11);
    tick();
    idle();
    chk("ovf_set", bus.ovf, 32'b0010);
    chk("stall_hold_data2", bus.out_data, 32'h11);
    chk("stall_hold_ch", bus.out_ch, 32'd0);
    chk("stall_hold_valid", bus.out_valid, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("ovf_deliver_ch", bus.out_ch, 32'd1);
    chk("ovf_deliver_data", bus.out_data, 32'h33);
    chk("ovf_still_set", bus.ovf, 32'b0010);
    bus.ovf_clr[1] = 1'b1;
    tick();
    idle();
    chk("ovf_cleared", bus.ovf, 32'd0);
    chk("ovf_drained", bus.out_valid, 32'd0);

    // Simultaneous overrun and clear: the set wins.
    bus.out_ready = 1'b0;
    strobe(0, 32'h5, 5'd0);
    tick();
    idle();
    tick();
    strobe(1, 32'h6, 5'd0);
    tick();
    strobe(1, 32'h7, 5'd0);
    bus.ovf_clr[1] = 1'b1;
    tick();
    idle();
    chk("set_wins", bus.ovf, 32'b0010);

    // Reset with a stalled result and two pending slots.
    strobe(2, 32'h8, 5'd0);
    tick();
    idle();
    chk("pre_rst_valid", bus.out_valid, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 32'd0);
    chk("async_rst_data", bus.out_data, 32'd0);
    chk("async_rst_ch", bus.out_ch, 32'd0);
    chk("async_rst_ovf", bus.ovf, 32'd0);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_discard", bus.out_valid, 32'd0);
    strobe(3, 32'h33, 5'd0);
    strobe(0, 32'h44, 5'd0);
    tick();
    idle();
    tick();
    chk("post_rst_first_ch", bus.out_ch, 32'd0);
    chk("post_rst_first_data", bus.out_data, 32'h44);
    tick();
    chk("post_rst_second_ch", bus.out_ch, 32'd3);
    chk("post_rst_second_data", bus.out_data, 32'h33);
    tick();
    chk("post_rst_empty", bus.out_valid, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
